button_press_classifier: RTL and testbench

Sits directly downstream of the button debouncer/edge detector, consuming its debounced level and its p_edge/n_edge pulses. It classifies each press gesture as a single click, a double click or a long press, and emits one-cycle event pulses for the UI/control logic. The block runs in the same clock domain as the debouncer, and all of its inputs are already synchronous and glitch-free.

---
 rtl/button_pkg.sv | 23 ++
 rtl/press_timer.sv | 23 ++
 rtl/button_press_classifier.sv | 119 +++++++++++
 tb/tb_button_press_classifier.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared button-path definitions: classifier states, tick defaults and clock rate.
// The debouncer uses the same clock constant.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS1   = 2'd1,
    GAP      = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  localparam int CLK_HZ            = 100_000_000;
  localparam int LONG_TICKS_DEF    = 100_000_000;
  localparam int DBL_GAP_TICKS_DEF = 30_000_000;

  function automatic int max_int(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/press_timer.sv
// Saturating up-counter used to time press and gap phases.
// Clear has priority over enable; the count holds at all-ones.
module press_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/button_press_classifier.sv
// Classifies debounced press gestures into single click, double click
// or long press, emitting registered one-cycle event pulses.
module button_press_classifier
  import button_pkg::*;
#(
  parameter int LONG_TICKS    = LONG_TICKS_DEF,
  parameter int DBL_GAP_TICKS = DBL_GAP_TICKS_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic debounced,
  input  logic p_edge,
  input  logic n_edge,
  output logic single_click,
  output logic double_click,
  output logic long_press,
  output logic long_active,
  output logic busy
);

  localparam int CNT_W =
    $clog2(max_int(LONG_TICKS, DBL_GAP_TICKS) + 1);

  localparam logic [CNT_W-1:0] LONG_LAST =
    CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'(DBL_GAP_TICKS - 1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] count;
  logic             rise;
  logic             fall;
  logic             long_hit;
  logic             gap_hit;
  logic             sc_nx;
  logic             dc_nx;
  logic             lp_nx;
  logic             tmr_clr;
  logic             tmr_en;
  logic             rel_exit;

  // Both edges at once is illegal upstream and is ignored;
  // a low level without n_edge still counts as a release.
  assign rise = p_edge & ~n_edge;
  assign fall = ~p_edge & (n_edge | ~debounced);

  assign long_hit = (count == LONG_LAST);
  assign gap_hit  = (count == GAP_LAST);

  always_comb begin
    state_nx = state;
    sc_nx    = 1'b0;
    dc_nx    = 1'b0;
    lp_nx    = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) state_nx = PRESS1;
      end
      PRESS1: begin
        if (long_hit) begin
          lp_nx    = 1'b1;
          state_nx = WAIT_REL;
        end else if (fall) begin
          state_nx = GAP;
        end
      end
      GAP: begin
        if (rise) begin
          dc_nx    = 1'b1;
          state_nx = WAIT_REL;
        end else if (gap_hit) begin
          sc_nx    = 1'b1;
          state_nx = IDLE;
        end
      end
      WAIT_REL: begin
        if (!debounced) state_nx = IDLE;
      end
    endcase
  end

  assign tmr_clr  = (state_nx != state);
  assign tmr_en   = (state == PRESS1) || (state == GAP);
  assign rel_exit = (state == WAIT_REL) && (state_nx == IDLE);

  press_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (tmr_clr),
    .enable  (tmr_en),
    .count   (count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      long_active  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nx;
      single_click <= sc_nx;
      double_click <= dc_nx;
      long_press   <= lp_nx;
      busy         <= (state_nx != IDLE);
      if (lp_nx) begin
        long_active <= 1'b1;
      end else if (rel_exit) begin
        long_active <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed bench for button_press_classifier with short tick settings.
// Event pulses are logged per clock edge and checked inside each scenario task.
module tb_button_press_classifier;

  logic clk = 1'b0;
  logic reset_n;
  logic debounced;
  logic p_edge;
  logic n_edge;
  logic single_click;
  logic double_click;
  logic long_press;
  logic long_active;
  logic busy;

  int tests  = 0;
  int errors = 0;

  int edge_cnt = 0;
  int sc_cnt, sc_first, sc_last;
  int dc_cnt, dc_last;
  int lp_cnt, lp_last;
  int la_cnt;
  int bf_edge;
  int multi_cnt;
  logic busy_q = 1'b0;

  button_press_classifier #(
    .LONG_TICKS    (20),
    .DBL_GAP_TICKS (10)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .debounced    (debounced),
    .p_edge       (p_edge),
    .n_edge       (n_edge),
    .single_click (single_click),
    .double_click (double_click),
    .long_press   (long_press),
    .long_active  (long_active),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Log pulses with the index of the edge that produced them.
  always @(negedge clk) begin
    if (single_click) begin
      sc_cnt++;
      if (sc_cnt == 1) sc_first = edge_cnt;
      sc_last = edge_cnt;
    end
    if (double_click) begin
      dc_cnt++;
      dc_last = edge_cnt;
    end
    if (long_press) begin
      lp_cnt++;
      lp_last = edge_cnt;
    end
    if (long_active) la_cnt++;
    if ((int'(single_click) + int'(double_click)
         + int'(long_press)) > 1) multi_cnt++;
    if (busy_q && !busy) bf_edge = edge_cnt;
    busy_q = busy;
  end

  task automatic clr_log();
    sc_cnt   = 0;
    sc_first = -1;
    sc_last  = -1;
    dc_cnt   = 0;
    dc_last  = -1;
    lp_cnt   = 0;
    lp_last  = -1;
    la_cnt   = 0;
    bf_edge  = -1;
  endtask

  task automatic step(input logic d, input logic p, input logic n);
    debounced = d;
    p_edge    = p;
    n_edge    = n;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic hold(input int k);
    for (int i = 0; i < k; i++) step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    debounced = 1'b0;
    p_edge    = 1'b0;
    n_edge    = 1'b0;
    clr_log();
    multi_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({single_click, double_click, long_press,
         long_active, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000",
        {single_click, double_click, long_press, long_active, busy});
    end
    reset_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    tests++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_illegal_edges();
    clr_log();
    step(1'b1, 1'b1, 1'b1);
    tests++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal_busy: got %b expected 0", busy);
    end
    hold(3);
    idle(15);
    tests++;
    if (sc_cnt + dc_cnt + lp_cnt !== 0) begin
      errors++;
      $display("FAIL illegal_events: got %0d expected 0",
        sc_cnt + dc_cnt + lp_cnt);
    end
  endtask

  task automatic test_single_click();
    int ne;
    clr_log();
    step(1'b1, 1'b1, 1'b0);
    tests++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_rise: got %b expected 1", busy);
    end
    hold(4);
    step(1'b0, 1'b0, 1'b1);
    ne = edge_cnt;
    idle(20);
    tests++;
    if (sc_cnt !== 1 || sc_last !== ne + 10) begin
      errors++;
      $display("FAIL single_pulse: got cnt=%0d at %0d expected cnt=1 at %0d",
        sc_cnt, sc_last, ne + 10);
    end
    tests++;
    if (dc_cnt + lp_cnt + la_cnt !== 0) begin
      errors++;
      $display("FAIL single_other: got %0d expected 0",
        dc_cnt + lp_cnt + la_cnt);
    end
    tests++;
    if (bf_edge !== ne + 10) begin
      errors++;
      $display("FAIL single_busy_fall: got %0d expected %0d",
        bf_edge, ne + 10);
    end
  endtask

  task automatic test_long_press();
    int pe;
    clr_log();
    step(1'b1, 1'b1, 1'b0);
    pe = edge_cnt;
    hold(29);
    tests++;
    if (long_active !== 1'b1) begin
      errors++;
      $display("FAIL long_active_held: got %b expected 1", long_active);
    end
    step(1'b0, 1'b0, 1'b1);
    tests++;
    if (long_active !== 1'b0) begin
      errors++;
      $display("FAIL long_active_clear: got %b expected 0", long_active);
    end
    idle(20);
    tests++;
    if (lp_cnt !== 1 || lp_last !== pe + 20) begin
      errors++;
      $display("FAIL long_pulse: got cnt=%0d at %0d expected cnt=1 at %0d",
        lp_cnt, lp_last, pe + 20);
    end
    tests++;
    if (la_cnt !== 10) begin
      errors++;
      $display("FAIL long_active_len: got %0d expected 10", la_cnt);
    end
    tests++;
    if (sc_cnt + dc_cnt !== 0) begin
      errors++;
      $display("FAIL long_other: got %0d expected 0", sc_cnt + dc_cnt);
    end
  endtask

  task automatic test_double_click();
    int p2;
    clr_log();
    step(1'b1, 1'b1, 1'b0);
    hold(2);
    step(1'b0, 1'b0, 1'b1);
    idle(3);
    step(1'b1, 1'b1, 1'b0);
    p2 = edge_cnt;
    hold(2);
    step(1'b0, 1'b0, 1'b1);
    tests++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL double_busy: got %b expected 0", busy);
    end
    idle(20);
    tests++;
    if (dc_cnt !== 1 || dc_last !== p2) begin
      errors++;
      $display("FAIL double_pulse: got cnt=%0d at %0d expected cnt=1 at %0d",
        dc_cnt, dc_last, p2);
    end
    tests++;
    if (sc_cnt + lp_cnt !== 0) begin
      errors++;
      $display("FAIL double_other: got %0d expected 0", sc_cnt + lp_cnt);
    end
  endtask

  task automatic test_slow_double();
    int n1;
    int n2;
    clr_log();
    step(1'b1, 1'b1, 1'b0);
    hold(2);
    step(1'b0, 1'b0, 1'b1);
    n1 = edge_cnt;
    idle(11);
    step(1'b1, 1'b1, 1'b0);
    hold(2);
    step(1'b0, 1'b0, 1'b1);
    n2 = edge_cnt;
    idle(20);
    tests++;
    if (sc_cnt !== 2 || sc_first !== n1 + 10 || sc_last !== n2 + 10) begin
      errors++;
      $display("FAIL slow_singles: got cnt=%0d at %0d,%0d expected 2 at %0d,%0d",
        sc_cnt, sc_first, sc_last, n1 + 10, n2 + 10);
    end
    tests++;
    if (dc_cnt !== 0) begin
      errors++;
      $display("FAIL slow_double: got %0d expected 0", dc_cnt);
    end
  endtask

  task automatic test_boundary();
    int ne;
    int pe;
    clr_log();
    step(1'b1, 1'b1, 1'b0);
    hold(2);
    step(1'b0, 1'b0, 1'b1);
    ne = edge_cnt;
    idle(9);
    step(1'b1, 1'b1, 1'b0);
    hold(2);
    step(1'b0, 1'b0, 1'b1);
    idle(20);
    tests++;
    if (dc_cnt !== 1 || dc_last !== ne + 10 || sc_cnt !== 0) begin
      errors++;
      $display("FAIL gap_edge: got dc=%0d at %0d sc=%0d expected dc=1 at %0d sc=0",
        dc_cnt, dc_last, sc_cnt, ne + 10);
    end
    clr_log();
    step(1'b1, 1'b1, 1'b0);
    pe = edge_cnt;
    hold(18);
    step(1'b0, 1'b0, 1'b1);
    ne = edge_cnt;
    idle(20);
    tests++;
    if (ne !== pe + 19 || lp_cnt !== 0) begin
      errors++;
      $display("FAIL hold19_long: got held=%0d lp=%0d expected held=19 lp=0",
        ne - pe, lp_cnt);
    end
    tests++;
    if (sc_cnt !== 1 || sc_last !== ne + 10) begin
      errors++;
      $display("FAIL hold19_single: got cnt=%0d at %0d expected cnt=1 at %0d",
        sc_cnt, sc_last, ne + 10);
    end
  endtask

  task automatic test_missed_release();
    int ne;
    clr_log();
    step(1'b1, 1'b1, 1'b0);
    hold(2);
    step(1'b0, 1'b0, 1'b0);
    ne = edge_cnt;
    idle(20);
    tests++;
    if (sc_cnt !== 1 || sc_last !== ne + 10) begin
      errors++;
      $display("FAIL missed_release: got cnt=%0d at %0d expected cnt=1 at %0d",
        sc_cnt, sc_last, ne + 10);
    end
  endtask

  task automatic test_reset_mid_gesture();
    int ne;
    clr_log();
    step(1'b1, 1'b1, 1'b0);
    hold(15);
    tests++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_busy_before: got %b expected 1", busy);
    end
    #2;
    reset_n = 1'b0;
    #1;
    tests++;
    if ({single_click, double_click, long_press,
         long_active, busy} !== 5'b0) begin
      errors++;
      $display("FAIL midreset_async: got %b expected 00000",
        {single_click, double_click, long_press, long_active, busy});
    end
    hold(2);
    reset_n = 1'b1;
    hold(1);
    step(1'b0, 1'b0, 1'b1);
    idle(25);
    tests++;
    if (sc_cnt + dc_cnt + lp_cnt !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_events: got ev=%0d busy=%b expected ev=0 busy=0",
        sc_cnt + dc_cnt + lp_cnt, busy);
    end
    step(1'b1, 1'b1, 1'b0);
    hold(2);
    step(1'b0, 1'b0, 1'b1);
    ne = edge_cnt;
    idle(15);
    tests++;
    if (sc_cnt !== 1 || sc_last !== ne + 10) begin
      errors++;
      $display("FAIL midreset_recover: got cnt=%0d at %0d expected cnt=1 at %0d",
        sc_cnt, sc_last, ne + 10);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_illegal_edges();
    test_single_click();
    test_long_press();
    test_double_click();
    test_slow_double();
    test_boundary();
    test_missed_release();
    test_reset_mid_gesture();
    tests++;
    if (multi_cnt !== 0) begin
      errors++;
      $display("FAIL exclusive_events: got %0d expected 0", multi_cnt);
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
